// File: rtl/rrf_free_list_if.sv
// Decode/commit-side bundle for the rename-register free-tag allocator.
// alloc_ok is the valid for alloc_tag1/alloc_tag2; a tag is consumed only when its alloc_req is high while alloc_ok is high and stall is low.
interface rrf_free_list_if #(
    parameter int TAG_W = 7
);
    logic             stall;
    logic             flush;
    logic             alloc_req1;
    logic             alloc_req2;
    logic             free_en1;
    logic [TAG_W-1:0] free_tag1;
    logic             free_en2;
    logic [TAG_W-1:0] free_tag2;
    logic             alloc_ok;
    logic [TAG_W-1:0] alloc_tag1;
    logic [TAG_W-1:0] alloc_tag2;
    logic [TAG_W:0]   free_count;
    logic             init_busy;
    logic             err_overflow;

    modport master (
        output stall, flush, alloc_req1, alloc_req2,
        output free_en1, free_tag1, free_en2, free_tag2,
        input  alloc_ok, alloc_tag1, alloc_tag2, free_count, init_busy, err_overflow
    );

    modport slave (
        input  stall, flush, alloc_req1, alloc_req2,
        input  free_en1, free_tag1, free_en2, free_tag2,
        output alloc_ok, alloc_tag1, alloc_tag2, free_count, init_busy, err_overflow
    );
endinterface

// File: rtl/rrf_free_list.sv
// Circular FIFO of free RRF tags: two pops per cycle to Decode, two pushes per cycle from commit.
// An init sequencer refills the FIFO with every tag after reset and after flush.
module rrf_free_list #(
    parameter int NUM_TAGS = 128,
    parameter int TAG_W    = 7
) (
    input  logic           clk,
    input  logic           reset_n,
    rrf_free_list_if.slave bus
);
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [TAG_W:0]   FULL   = (TAG_W+1)'(NUM_TAGS);
    localparam logic [TAG_W:0]   CNT2   = (TAG_W+1)'(2);
    localparam logic [TAG_W-1:0] PTR1   = TAG_W'(1);
    localparam logic [TAG_W-1:0] PTR2   = TAG_W'(2);

    state_t           r_state;
    logic [TAG_W-1:0] r_fifo [NUM_TAGS];
    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [TAG_W-1:0] r_init_ptr;
    logic [TAG_W:0]   r_count;
    logic             r_err_ovf;

    logic             w_run;
    logic             w_alloc_ok;
    logic             w_advance;
    logic [1:0]       w_pops;
    logic [1:0]       w_push_req;
    logic [1:0]       w_pushes;
    logic [TAG_W:0]   w_space;
    logic [TAG_W-1:0] w_head1;
    logic [TAG_W-1:0] w_init_nxt;
    logic             w_we0;
    logic             w_we1;
    logic [TAG_W-1:0] w_wa0;
    logic [TAG_W-1:0] w_wa1;
    logic [TAG_W-1:0] w_wd0;
    logic [TAG_W-1:0] w_wd1;

    assign w_run      = (r_state == ST_RUN);
    assign w_alloc_ok = w_run && (r_count >= CNT2);
    assign w_advance  = !bus.stall && !bus.flush;
    assign w_head1    = r_head + PTR1;
    assign w_init_nxt = r_init_ptr + PTR2;
    assign w_push_req = {1'b0, bus.free_en1} + {1'b0, bus.free_en2};

    always_comb begin
        w_pops = 2'd0;
        if (w_advance && w_alloc_ok && bus.alloc_req1) begin
            w_pops = bus.alloc_req2 ? 2'd2 : 2'd1;
        end
    end

    // Room is measured after this cycle's pops, so a pop can make space for a same-cycle push.
    assign w_space = FULL - (r_count - {{(TAG_W-1){1'b0}}, w_pops});

    always_comb begin
        w_pushes = 2'd0;
        if (w_advance && w_run) begin
            if (w_space >= {{(TAG_W-1){1'b0}}, w_push_req}) begin
                w_pushes = w_push_req;
            end else begin
                w_pushes = w_space[1:0];
            end
        end
    end

    always_comb begin
        w_we0 = 1'b0;
        w_we1 = 1'b0;
        w_wa0 = r_tail;
        w_wa1 = r_tail + PTR1;
        w_wd0 = bus.free_en1 ? bus.free_tag1 : bus.free_tag2;
        w_wd1 = bus.free_tag2;
        if (w_advance && !w_run) begin
            w_we0 = 1'b1;
            w_we1 = 1'b1;
            w_wa0 = r_init_ptr;
            w_wa1 = r_init_ptr + PTR1;
            w_wd0 = r_init_ptr;
            w_wd1 = r_init_ptr + PTR1;
        end else begin
            w_we0 = (w_pushes != 2'd0);
            w_we1 = (w_pushes == 2'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (w_we0) r_fifo[w_wa0] <= w_wd0;
        if (w_we1) r_fifo[w_wa1] <= w_wd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_INIT;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_init_ptr <= '0;
            r_err_ovf  <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.flush) begin
                r_state    <= ST_INIT;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                r_init_ptr <= '0;
            end else if (r_state == ST_INIT) begin
                r_init_ptr <= w_init_nxt;
                r_tail     <= r_tail + PTR2;
                r_count    <= r_count + CNT2;
                if (w_init_nxt == '0) r_state <= ST_RUN;
            end else begin
                r_head  <= r_head + {{(TAG_W-2){1'b0}}, w_pops};
                r_tail  <= r_tail + {{(TAG_W-2){1'b0}}, w_pushes};
                r_count <= r_count - {{(TAG_W-1){1'b0}}, w_pops}
                                   + {{(TAG_W-1){1'b0}}, w_pushes};
                if (w_pushes != w_push_req) r_err_ovf <= 1'b1;
            end
        end
    end

    assign bus.alloc_ok     = w_alloc_ok;
    assign bus.alloc_tag1   = w_alloc_ok ? r_fifo[r_head]  : '0;
    assign bus.alloc_tag2   = w_alloc_ok ? r_fifo[w_head1] : '0;
    assign bus.free_count   = r_count;
    assign bus.init_busy    = !w_run;
    assign bus.err_overflow = r_err_ovf;
endmodule

// File: tb/tb_rrf_free_list.sv
// Bench for rrf_free_list: a queue-based model of the free list predicts every cycle's outputs.
module tb_rrf_free_list;
    localparam int N = 128;
    localparam int W = 25;

    logic clk;
    logic reset_n;
    logic mon_en;
    int   n_checks;
    int   n_fail;

    logic [W-1:0] exp_q[$];
    logic [6:0]   fq[$];
    logic [6:0]   out_q[$];
    bit           m_run;
    bit           m_err;

    rrf_free_list_if #(.TAG_W(7)) bus ();

    rrf_free_list #(.NUM_TAGS(N), .TAG_W(7)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] model_out();
        logic       ok;
        logic [6:0] t1;
        logic [6:0] t2;
        ok = m_run && (fq.size() >= 2);
        t1 = 7'd0;
        t2 = 7'd0;
        if (ok) begin
            t1 = fq[0];
            t2 = fq[1];
        end
        return {ok, t1, t2, 8'(fq.size()), !m_run, m_err};
    endfunction

    function automatic void model_reset();
        fq.delete();
        out_q.delete();
        m_run = 1'b0;
        m_err = 1'b0;
    endfunction

    function automatic void give_back(input logic [6:0] t);
        int idx[$];
        if (fq.size() < N) begin
            fq.push_back(t);
            idx = out_q.find_first_index(x) with (x == t);
            if (idx.size() > 0) out_q.delete(idx[0]);
        end else begin
            m_err = 1'b1;
        end
    endfunction

    function automatic void model_apply(input bit s, f, r1, r2, e1, input logic [6:0] t1,
                                        input bit e2, input logic [6:0] t2);
        if (s) return;
        if (f) begin
            fq.delete();
            out_q.delete();
            m_run = 1'b0;
        end else if (!m_run) begin
            fq.push_back(7'(fq.size()));
            fq.push_back(7'(fq.size()));
            if (fq.size() == N) m_run = 1'b1;
        end else begin
            if (fq.size() >= 2 && r1) begin
                out_q.push_back(fq.pop_front());
                if (r2) out_q.push_back(fq.pop_front());
            end
            if (e1) give_back(t1);
            if (e2) give_back(t2);
        end
    endfunction

    task automatic step(input bit s, f, r1, r2, e1, input logic [6:0] t1,
                        input bit e2, input logic [6:0] t2);
        exp_q.push_back(model_out());
        bus.stall      = s;
        bus.flush      = f;
        bus.alloc_req1 = r1;
        bus.alloc_req2 = r2;
        bus.free_en1   = e1;
        bus.free_tag1  = t1;
        bus.free_en2   = e2;
        bus.free_tag2  = t2;
        if (!reset_n) model_reset();
        else model_apply(s, f, r1, r2, e1, t1, e2, t2);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 7'd0, 0, 7'd0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic [W-1:0] e;
            logic [W-1:0] a;
            a = {bus.alloc_ok, bus.alloc_tag1, bus.alloc_tag2, bus.free_count,
                 bus.init_busy, bus.err_overflow};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t actual ok=%0b tags=%0d,%0d cnt=%0d busy=%0b err=%0b expected ok=%0b tags=%0d,%0d cnt=%0d busy=%0b err=%0b",
                             $time, a[24], a[23:17], a[16:10], a[9:2], a[1], a[0],
                             e[24], e[23:17], e[16:10], e[9:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        logic [6:0] t1;
        logic [6:0] t2;
        bit         s, f, r1, r2, e1, e2;
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        reset_n  = 1'b0;
        bus.stall = 0; bus.flush = 0; bus.alloc_req1 = 0; bus.alloc_req2 = 0;
        bus.free_en1 = 0; bus.free_tag1 = 0; bus.free_en2 = 0; bus.free_tag2 = 0;
        model_reset();
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // reset state, then full init sequence and first pair grants
        step(0, 0, 1, 1, 1, 7'd9, 1, 7'd3);
        idle(2);
        reset_n = 1'b1;
        idle(65);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 7'd0, 0, 7'd0);

        // drain to one tag, ignored requests, then wrap onto freed entries
        while (fq.size() > 2) step(0, 0, 1, 1, 0, 7'd0, 0, 7'd0);
        step(0, 0, 1, 0, 0, 7'd0, 0, 7'd0);
        step(0, 0, 1, 0, 0, 7'd0, 0, 7'd0);
        step(0, 0, 1, 1, 0, 7'd0, 0, 7'd0);
        step(0, 0, 0, 0, 1, 7'd10, 1, 7'd20);
        step(0, 0, 1, 0, 0, 7'd0, 0, 7'd0);
        step(0, 0, 0, 0, 0, 7'd0, 1, 7'd127);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 700; i++) begin
            s  = ($urandom_range(0, 9) == 0);
            f  = ($urandom_range(0, 199) == 0);
            r1 = ($urandom_range(0, 3) != 0);
            r2 = ($urandom_range(0, 2) != 0);
            e1 = 0; e2 = 0; t1 = 7'($urandom); t2 = 7'($urandom);
            if (out_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                e1 = 1;
                t1 = out_q[$urandom_range(0, out_q.size() - 1)];
            end
            if (out_q.size() > 1 && $urandom_range(0, 2) == 0) begin
                e2 = 1;
                t2 = out_q[$urandom_range(0, out_q.size() - 1)];
                if (e1 && t2 == t1) e2 = 0;
            end
            if ($urandom_range(0, 49) == 0) e1 = 1;
            step(s, f, r1, r2, e1, t1, e2, t2);
        end

        // clean restart, then flush with count=60 and live traffic
        reset_n = 1'b0;
        model_reset();
        idle(2);
        reset_n = 1'b1;
        idle(65);
        for (int i = 0; i < 34; i++) step(0, 0, 1, 1, 0, 7'd0, 0, 7'd0);
        step(0, 1, 1, 1, 1, 7'd3, 0, 7'd0);
        idle(65);

        // stall mid-init with flush and requests held
        step(0, 1, 0, 0, 0, 7'd0, 0, 7'd0);
        idle(10);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 1, 1, 7'd4, 0, 7'd0);
        idle(55);

        // overflow on a full list, then asynchronous reset clears it
        step(0, 0, 0, 0, 1, 7'd5, 0, 7'd0);
        idle(2);
        mon_en = 1'b0;
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("err_before_reset", 32'(bus.err_overflow), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_err_clear", 32'(bus.err_overflow), 32'd0);
        chk("async_count_clear", 32'(bus.free_count), 32'd0);
        chk("async_init_busy", 32'(bus.init_busy), 32'd1);
        chk("async_alloc_ok", 32'(bus.alloc_ok), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
